fetch_pc_seq: RTL and testbench
===============================

# fetch_pc_seq

Fetch-stage PC sequencer for the in-order MIPS-style pipeline. Holds the architectural fetch PC and issues one instruction-memory request at a time over an addr_ok/data_ok handshake. Delivers each fetched instruction to decode under a valid/allowin handshake. Applies taken-branch and jump redirects after the delay slot, and exception redirects immediately with flush.

## Interface
- RESET_PC, 32'hBFC0_0000, first fetch address after reset
- clk  in  1  clock; all state updates on the rising edge
- resetn  in  1  asynchronous, active-low reset
- inst_req  out  1  request valid to instruction memory
- inst_addr  out  32  request address; always word-aligned
- inst_addr_ok  in  1  request accepted this cycle when inst_req is also 1
- inst_data_ok  in  1  read data returned this cycle
- inst_rdata  in  32  read data, valid with inst_data_ok
- ds_allowin  in  1  decode can accept an instruction this cycle
- fs_valid  out  1  fs_inst/fs_pc hold a deliverable instruction
- fs_pc  out  32  PC of the delivered instruction
- fs_inst  out  32  instruction word
- redir_valid  in  1  one-cycle pulse from decode: taken branch, j/jal or jr
- redir_target  in  32  resolved target, already formed by the decode next-PC datapath
- ex_signal  in  1  one-cycle exception/eret pulse from the commit stage
- ex_addr  in  32  exception or return vector

## Operation
- Registers:
  - pc: address of the current or next request.
  - pend_valid/pend_target: saved redirect.
  - discard: the in-flight response must be dropped.
  - out_pc/out_inst: the delivery buffer.
  - state.
- States:
  - REQ: inst_req=1, inst_addr=pc. On inst_addr_ok, go to WAIT.
  - WAIT: inst_req=0. On inst_data_ok:
    - If discard=1, clear discard, go to REQ, leave pc unchanged.
    - Otherwise capture out_pc=pc and out_inst=inst_rdata, then go to HOLD.
  - HOLD: fs_valid=1. When ds_allowin=1 the instruction is delivered; go to REQ.
  - On delivery, pc is updated: pc <= pend_valid ? pend_target : pc+4, and pend_valid is cleared.
  - Address arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- Delay slot: a redir_valid pulse always arrives while the delay-slot instruction (branch PC+4) is being fetched or held. The target is therefore stored in pend_target and applied only when the next pc update occurs, i.e. after the delay slot is delivered.
- Exception (ex_signal=1), highest priority, in every state:
  - pc <= ex_addr, pend_valid <= 0, fs_valid drops next cycle.
  - The held instruction is discarded.
  - In WAIT without inst_data_ok this cycle: set discard=1 and stay in WAIT.
  - In WAIT with inst_data_ok this cycle: drop the data and go to REQ.
  - In HOLD, or in REQ (including a same-cycle inst_addr_ok): go to REQ with the new pc. If inst_addr_ok coincided in REQ, go to WAIT with discard=1 instead.
- ex_signal and redir_valid in the same cycle: the exception wins and the redirect is ignored.
- A second redir_valid while pend_valid=1 overwrites pend_target; decode never generates this.

## Timing
- Reset values:
  - state=REQ, pc=RESET_PC, inst_req=1 in the first cycle after reset release.
  - fs_valid=0, fs_pc=0, fs_inst=0.
  - pend_valid=0, discard=0.
- Minimum loop is 3 cycles per instruction: the request cycle (addr_ok the same cycle), data_ok the next cycle, then the HOLD cycle with ds_allowin=1.
- inst_req stays asserted with a stable inst_addr until inst_addr_ok. The only exception is an ex_signal, which changes inst_addr the next cycle.
- fs_valid, fs_pc and fs_inst are registered outputs. They are stable while fs_valid=1 and ds_allowin=0.
- resetn assertion mid-transaction returns all state to reset values immediately. The memory side is reset by the same resetn.

## Structure
- Shared cpu package holds the state encoding (REQ/WAIT/HOLD), the RESET_PC default and the 32'd4 increment constant.
- Sub-module: the existing combinational next-PC selector (ex/jr/j/branch/sequential mux), placed in decode. It produces redir_target and is not instantiated here.
- The block is a single module with a single FSM and no further sub-modules.

## Test plan
- Reset, memory always ready, ds_allowin=1 -> requests go to BFC00000, BFC00004, BFC00008. fs_pc follows the same order, one instruction per 3 cycles.
- Branch: redir_valid with target 0x80001000 while pc=BFC00008 is in WAIT -> BFC00008 is delivered, then the next request is 80001000.
- ds_allowin=0 for 5 cycles in HOLD -> fs_valid, fs_pc and fs_inst stay constant and no new request is issued.
- ex_signal (ex_addr=BFC00380) in WAIT, data_ok 2 cycles later -> the returned data is dropped, fs_valid stays 0, the next request is BFC00380 and the pending redirect is cleared.
- ex_signal and redir_valid in the same cycle -> the next fetch is ex_addr and the branch target is never fetched.
- pc=FFFFFFFC delivered -> the next request is 00000000.

Source files
------------

// File: rtl/fetch_pc_seq_pkg.sv
// fetch_pc_seq_pkg: shared fetch-stage constants (FSM encoding, reset vector, PC step).
package fetch_pc_seq_pkg;
    localparam logic [1:0]  ST_REQ       = 2'd0;
    localparam logic [1:0]  ST_WAIT      = 2'd1;
    localparam logic [1:0]  ST_HOLD      = 2'd2;
    localparam logic [31:0] DEF_RESET_PC = 32'hBFC0_0000;
    localparam logic [31:0] PC_INC       = 32'd4;

    function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic take, input logic [31:0] tgt);
        return take ? tgt : pc + PC_INC;
    endfunction
endpackage

// File: rtl/fetch_pc_seq.sv
// fetch_pc_seq: fetch PC sequencer with one outstanding imem request, delay-slot
// redirect buffering and immediate exception redirect with response discard.
module fetch_pc_seq
    import fetch_pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        ds_allowin,
    output logic        fs_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    input  logic        ex_signal,
    input  logic [31:0] ex_addr
);
    logic [1:0]  state;
    logic [31:0] pc;
    logic        pend_valid;
    logic [31:0] pend_target;
    logic        discard;
    logic        ex_wait;

    assign inst_req  = state == ST_REQ;
    assign inst_addr = {pc[31:2], 2'b00};
    // an exception leaves a request in flight when it was just accepted or is still outstanding
    assign ex_wait   = (state == ST_REQ && inst_addr_ok) || (state == ST_WAIT && !inst_data_ok);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_REQ;
            pc          <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_target <= 32'd0;
            discard     <= 1'b0;
            fs_valid    <= 1'b0;
            fs_pc       <= 32'd0;
            fs_inst     <= 32'd0;
        end else if (ex_signal) begin
            pc         <= ex_addr;
            pend_valid <= 1'b0;
            fs_valid   <= 1'b0;
            discard    <= ex_wait;
            state      <= ex_wait ? ST_WAIT : ST_REQ;
        end else begin
            if (redir_valid) begin
                pend_valid  <= 1'b1;
                pend_target <= redir_target;
            end
            case (state)
                ST_REQ: if (inst_addr_ok) state <= ST_WAIT;
                ST_WAIT: if (inst_data_ok) begin
                    if (discard) begin
                        discard <= 1'b0;
                        state   <= ST_REQ;
                    end else begin
                        fs_pc    <= pc;
                        fs_inst  <= inst_rdata;
                        fs_valid <= 1'b1;
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: if (ds_allowin) begin
                    // a redirect arriving in the delivery cycle still belongs after this delay slot
                    pc         <= next_pc(pc, redir_valid | pend_valid, redir_valid ? redir_target : pend_target);
                    pend_valid <= 1'b0;
                    fs_valid   <= 1'b0;
                    state      <= ST_REQ;
                end
                default: state <= ST_REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_pc_seq.sv
// tb_fetch_pc_seq: directed self-checking bench for fetch_pc_seq.
module tb_fetch_pc_seq;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = 32'd0;
    logic        ds_allowin = 1'b0;
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_target = 32'd0;
    logic        ex_signal = 1'b0;
    logic [31:0] ex_addr = 32'd0;
    int          errors = 0;
    int          checks = 0;

    fetch_pc_seq dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .ds_allowin(ds_allowin),
        .fs_valid(fs_valid), .fs_pc(fs_pc), .fs_inst(fs_inst),
        .redir_valid(redir_valid), .redir_target(redir_target),
        .ex_signal(ex_signal), .ex_addr(ex_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic req(input string tag, input logic [31:0] addr);
        chk({tag, ".req"}, 32'(inst_req), 32'd1);
        chk({tag, ".addr"}, inst_addr, addr);
        inst_addr_ok = 1'b1;
        step();
        inst_addr_ok = 1'b0;
        chk({tag, ".wait"}, 32'(inst_req), 32'd0);
    endtask

    task automatic data(input logic [31:0] rd);
        inst_data_ok = 1'b1;
        inst_rdata   = rd;
        step();
        inst_data_ok = 1'b0;
        inst_rdata   = 32'd0;
    endtask

    task automatic deliver(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        chk({tag, ".valid"}, 32'(fs_valid), 32'd1);
        chk({tag, ".pc"}, fs_pc, pc);
        chk({tag, ".inst"}, fs_inst, inst);
        ds_allowin = 1'b1;
        step();
        ds_allowin = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] rd);
        req(tag, addr);
        data(rd);
        deliver(tag, addr, rd);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst.req", 32'(inst_req), 32'd1);
        chk("rst.addr", inst_addr, 32'hBFC0_0000);
        chk("rst.valid", 32'(fs_valid), 32'd0);
        chk("rst.pc", fs_pc, 32'd0);
        chk("rst.inst", fs_inst, 32'd0);
        resetn = 1'b1;

        fetch("seq0", 32'hBFC0_0000, 32'h1111_0000);
        fetch("seq1", 32'hBFC0_0004, 32'h1111_0004);

        // branch target taken after the BFC00008 delay slot is delivered
        req("br", 32'hBFC0_0008);
        redir_valid  = 1'b1;
        redir_target = 32'h8000_1000;
        step();
        redir_valid = 1'b0;
        data(32'h1111_0008);
        deliver("br", 32'hBFC0_0008, 32'h1111_0008);

        // decode stall keeps the delivery buffer stable with no new request
        req("stall", 32'h8000_1000);
        data(32'h2222_1000);
        for (int i = 0; i < 5; i++) begin
            chk("stall.valid", 32'(fs_valid), 32'd1);
            chk("stall.pc", fs_pc, 32'h8000_1000);
            chk("stall.inst", fs_inst, 32'h2222_1000);
            chk("stall.noreq", 32'(inst_req), 32'd0);
            step();
        end
        deliver("stall", 32'h8000_1000, 32'h2222_1000);

        // exception in WAIT drops the late response and the pending redirect
        req("exw", 32'h8000_1004);
        redir_valid  = 1'b1;
        redir_target = 32'h1234_5678;
        step();
        redir_valid = 1'b0;
        ex_signal   = 1'b1;
        ex_addr     = 32'hBFC0_0380;
        step();
        ex_signal = 1'b0;
        chk("exw.stillwait", 32'(inst_req), 32'd0);
        step();
        data(32'hDEAD_BEEF);
        chk("exw.novalid", 32'(fs_valid), 32'd0);
        fetch("exw.vec", 32'hBFC0_0380, 32'h3333_0380);
        chk("exw.nopend", inst_addr, 32'hBFC0_0384);

        // exception and redirect together in HOLD: exception wins
        req("exr", 32'hBFC0_0384);
        data(32'h3333_0384);
        ex_signal    = 1'b1;
        ex_addr      = 32'h0000_0100;
        redir_valid  = 1'b1;
        redir_target = 32'h8000_2000;
        step();
        ex_signal   = 1'b0;
        redir_valid = 1'b0;
        chk("exr.drop", 32'(fs_valid), 32'd0);
        fetch("exr.vec", 32'h0000_0100, 32'h4444_0100);
        chk("exr.seq", inst_addr, 32'h0000_0104);

        // exception in REQ without addr_ok, then wraparound past FFFFFFFC
        ex_signal = 1'b1;
        ex_addr   = 32'hFFFF_FFFC;
        step();
        ex_signal = 1'b0;
        fetch("wrap", 32'hFFFF_FFFC, 32'h5555_FFFC);
        chk("wrap.zero", inst_addr, 32'h0000_0000);

        // exception coinciding with addr_ok: response must be discarded
        inst_addr_ok = 1'b1;
        ex_signal    = 1'b1;
        ex_addr      = 32'hBFC0_0100;
        step();
        inst_addr_ok = 1'b0;
        ex_signal    = 1'b0;
        chk("exa.wait", 32'(inst_req), 32'd0);
        data(32'hBAD0_0000);
        chk("exa.novalid", 32'(fs_valid), 32'd0);
        chk("exa.addr", inst_addr, 32'hBFC0_0100);

        // asynchronous reset mid-transaction
        req("rst2", 32'hBFC0_0100);
        #1 resetn = 1'b0;
        #1;
        chk("rst2.req", 32'(inst_req), 32'd1);
        chk("rst2.addr", inst_addr, 32'hBFC0_0000);
        chk("rst2.valid", 32'(fs_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
